serial_add_seq: RTL and testbench
=================================

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal 2..32).
REQ-002 ck  in  1  single clock, all state rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset (rst=0 clears all state immediately).
REQ-004 start  in  1  request an addition; sampled only in IDLE.
REQ-005 op_a  in  WIDTH  operand A, captured on the accepting edge.
REQ-006 op_b  in  WIDTH  operand B, captured on the accepting edge.
REQ-007 cin  in  1  initial carry, captured on the accepting edge.
REQ-008 fa_a  out  1  operand-A bit to the downstream full-adder stage.
REQ-009 fa_b  out  1  operand-B bit to the full-adder stage.
REQ-010 fa_ci  out  1  carry-in bit to the full-adder stage.
REQ-011 fa_s  in  1  registered sum bit from the full-adder stage, valid one cycle after its inputs.
REQ-012 busy  out  1  high in SHIFT, DRAIN and DONE.
REQ-013 done  out  1  one-cycle pulse; sum and cout valid.
REQ-014 sum  out  WIDTH  assembled result.
REQ-015 cout  out  1  final carry-out.

Function
REQ-016 FSM states IDLE, SHIFT, DRAIN, DONE; all flops (FSM, shift regs, counter, carry, sum, cout, valid flag) reset asynchronously.
REQ-017 IDLE: start=1 at an edge -> latch op_a/op_b into LSB-first shift regs, carry<=cin, bit counter<=0, state<=SHIFT; start=0 -> stay.
REQ-018 SHIFT, counter=k: fa_a=A[k], fa_b=B[k], fa_ci=carry; at edge: carry<=majority(A[k],B[k],carry), shift regs advance, counter<=k+1.
REQ-019 SHIFT lasts exactly WIDTH cycles; edge ending counter=WIDTH-1 -> DRAIN.
REQ-020 fa_a, fa_b, fa_ci SHALL be 0 in IDLE, DRAIN, DONE.
REQ-021 Capture: registered flag s_vld<=(state==SHIFT); on each edge with s_vld=1, sum<={fa_s, sum[WIDTH-1:1]} (fa_s enters MSB, shifts right).
REQ-022 DRAIN: one cycle, captures final bit; edge -> DONE, cout<=carry.
REQ-023 DONE: done=1 for exactly one cycle; edge -> IDLE.
REQ-024 Latency: start accepted at edge E0 -> done high during cycle after edge E0+WIDTH+1 (WIDTH+2 cycles after acceptance).
REQ-025 sum and cout SHALL hold stable from done until the next accepting edge; sum is not cleared on start, only overwritten by shifting.
REQ-026 start while busy=1 SHALL be ignored (no relatch, no extension); start in DONE is ignored; back-to-back: start held high re-accepts at first IDLE edge.
REQ-027 Arithmetic: {cout,sum} = op_a + op_b + cin modulo 2^(WIDTH+1), full wrap on overflow.
REQ-028 fa_s SHALL be ignored whenever s_vld=0.

Reset
REQ-029 rst=0 at any time, including mid-SHIFT or DRAIN: state=IDLE, busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_ci=0, counter=0, carry=0, s_vld=0; no completion is produced for the aborted operation.
REQ-030 Release of rst takes effect at the next rising edge; start sampled on that edge is honoured.

Verification (WIDTH=8; bench models full-adder stage as s registered = a^b^ci, 1-cycle latency)
REQ-031 op_a=0x5A, op_b=0x3C, cin=0, start pulse -> done exactly 10 cycles after accept, sum=0x96, cout=0.
REQ-032 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple).
REQ-033 op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1; fa_ci=1 on every SHIFT cycle.
REQ-034 start re-pulsed with new operands at cycles 3 and 9 after accept -> ignored; result matches first operands; sum/cout hold after done until next accept.
REQ-035 rst=0 asserted during SHIFT counter=4 -> all outputs zero same cycle, no done pulse; subsequent 0x12+0x34 cin=0 -> sum=0x46, cout=0.
REQ-036 Random regression: 1000 operand triples, start held high continuously -> every done matches op_a+op_b+cin, back-to-back spacing WIDTH+3 cycles.

Source files
------------

// File: rtl/serial_add_seq_if.sv
// -----------------------------------------------------------------------------
// serial_add_seq_if
//
// Groups every non-clock, non-reset signal of serial_add_seq.
//
// Request side (master -> slave)
//   start  : request an addition (sampled by the adder only while idle)
//   op_a   : operand A, captured on the accepting edge
//   op_b   : operand B, captured on the accepting edge
//   cin    : initial carry, captured on the accepting edge
//
// Result side (slave -> master)
//   busy   : adder is working on an operation (SHIFT, DRAIN or DONE)
//   done   : one-cycle pulse, sum/cout are valid
//   sum    : assembled result
//   cout   : final carry-out
//
// Full-adder stage link
//   fa_a, fa_b, fa_ci : bit operands presented to the external full-adder
//                       stage (slave -> master)
//   fa_s              : registered sum bit back from that stage, valid one
//                       cycle after fa_a/fa_b/fa_ci (master -> slave)
//
// Handshake: a request is accepted on any rising edge where start=1 and
// busy=0. Requests made while busy=1 are ignored, not queued. done rises
// exactly once per accepted request; sum/cout stay stable from done until
// the next accepting edge. Holding start high re-accepts on the first edge
// seen while idle.
// -----------------------------------------------------------------------------
interface serial_add_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic             fa_a;
  logic             fa_b;
  logic             fa_ci;
  logic             fa_s;

  // The adder itself.
  modport slave (
    input  start, op_a, op_b, cin, fa_s,
    output busy, done, sum, cout, fa_a, fa_b, fa_ci
  );

  // Requester plus the external full-adder stage.
  modport master (
    output start, op_a, op_b, cin, fa_s,
    input  busy, done, sum, cout, fa_a, fa_b, fa_ci
  );
endinterface

// File: rtl/serial_add_seq.sv
// -----------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial adder sequencer. Operands are latched into LSB-first shift
// registers and presented one bit per cycle to an external, registered
// full-adder stage. The carry chain is kept locally, and the sum bits that
// come back from the stage one cycle later are shifted into the result
// register from the MSB end, so after WIDTH captures bit 0 sits at sum[0].
//
// Ports
//   ck        : clock, all state on the rising edge
//   rst       : asynchronous active-low reset
//   bus       : serial_add_seq_if slave modport (request, result, FA link)
//   dbg_state : current FSM state (0 IDLE, 1 SHIFT, 2 DRAIN, 3 DONE)
//
// Timeline for a request accepted on edge E0:
//   cycles 1..WIDTH   : SHIFT, bit k = cycle k+1 drives fa_a/fa_b/fa_ci
//   cycle  WIDTH+1    : DRAIN, last sum bit comes back and is captured
//   cycle  WIDTH+2    : DONE, done=1, sum/cout valid
//   next edge         : back to IDLE; start is sampled again on the edge after
// -----------------------------------------------------------------------------
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic                   ck,
  input  logic                   rst,
  serial_add_seq_if.slave        bus,
  output logic [1:0]             dbg_state
);

  // Counter must be able to hold WIDTH after the final increment.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_r;
  logic             s_vld;

  logic             accept;
  logic             in_shift;
  logic             carry_nxt;

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  assign accept   = (state == IDLE) && bus.start;
  assign in_shift = (state == SHIFT);

  // Majority of the current bit pair and the running carry.
  assign carry_nxt = (a_sr[0] & b_sr[0]) |
                     (a_sr[0] & carry)   |
                     (b_sr[0] & carry);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // SHIFT lasts exactly WIDTH cycles, one per operand bit.
        if (cnt == LAST_BIT) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        // start is deliberately not looked at here; it is only honoured
        // from IDLE.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand shift registers, bit counter and carry chain
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.op_a;
      b_sr  <= bus.op_b;
      cnt   <= '0;
      carry <= bus.cin;
    end else if (in_shift) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      cnt   <= cnt + CW'(1);
      carry <= carry_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture
  //
  // The full-adder stage answers one cycle after it is driven, so the capture
  // enable is simply "we were in SHIFT last cycle". That makes the last
  // capture land on the DRAIN edge and keeps sum untouched from DONE until
  // the next SHIFT's bits start arriving. sum is never cleared on accept; it
  // is fully overwritten after WIDTH captures.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      s_vld  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      s_vld <= in_shift;
      if (s_vld) begin
        sum_r <= {bus.fa_s, sum_r[WIDTH-1:1]};
      end
      if (state == DRAIN) begin
        // carry already holds the carry out of the MSB by now.
        cout_r <= carry;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Full-adder operands are forced low outside SHIFT so the stage sees a
  // quiet input whenever its answer is going to be ignored anyway.
  assign bus.fa_a  = in_shift & a_sr[0];
  assign bus.fa_b  = in_shift & b_sr[0];
  assign bus.fa_ci = in_shift & carry;

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_r;
  assign bus.cout  = cout_r;

  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_seq.sv
// -----------------------------------------------------------------------------
// tb_serial_add_seq
//
// Directed and random checks of serial_add_seq with WIDTH=8. The external
// full-adder stage is modelled as a registered a^b^ci. Expected results come
// from plain integer addition; expected full-adder drive comes from the
// carry into each bit position computed arithmetically.
// -----------------------------------------------------------------------------
module tb_serial_add_seq;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  serial_add_seq_if #(.WIDTH(W)) bus ();

  serial_add_seq #(.WIDTH(W)) dut (
    .ck        (ck),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Full-adder stage: registered sum bit, one cycle latency.
  logic fa_s_q = 1'b0;
  always @(posedge ck) fa_s_q <= bus.fa_a ^ bus.fa_b ^ bus.fa_ci;
  assign bus.fa_s = fa_s_q;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W:0] exp_q[$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Carry entering bit position k of a + b + c.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    int mask;
    int s;
    mask = (1 << k) - 1;
    s = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    return s[k];
  endfunction

  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one request with a start pulse, full per-cycle checking.
  //   repulse : re-pulse start with junk operands in cycles 3 and 9
  //   rel_rst : release reset on the same edge that samples start
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit repulse, input bit rel_rst, input string tag);
    int         n_done;
    logic [W:0] e;
    logic [W:0] res;
    logic [2:0] exp_fa;

    @(negedge ck);
    if (rel_rst) rst = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    exp_q.push_back(model_add(a, b, c));
    @(posedge ck);  // accepting edge
    n_done = 0;
    for (int n = 1; n <= W + 6; n++) begin
      @(negedge ck);
      if (n == 1) begin
        // Operands must not matter after the accepting edge.
        bus.start = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        bus.cin   = 1'($urandom);
      end
      if (n <= W) begin
        exp_fa = {a[n-1], b[n-1], carry_into(a, b, c, n - 1)};
        check({tag, "_fa_shift"}, 32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 32'(exp_fa));
      end else begin
        check({tag, "_fa_quiet"}, 32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 32'(0));
      end
      if (bus.done) begin
        n_done = n;
        break;
      end
      if (repulse && (n == 3 || n == 9)) begin
        bus.start = 1'b1;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        bus.cin   = 1'($urandom);
      end else if (repulse && n == 4) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(n_done), 32'(W + 2));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'(1));
    e   = exp_q.pop_front();
    res = {bus.cout, bus.sum};
    check({tag, "_result"}, 32'(res), 32'(e));
    // done is a single-cycle pulse, result holds while idle.
    for (int h = 0; h < 3; h++) begin
      @(negedge ck);
      check({tag, "_done_low"}, 32'({bus.done, bus.busy}), 32'(0));
      check({tag, "_hold"}, 32'({bus.cout, bus.sum}), 32'(e));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   e;
    int           waited;
    int           last_done;

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;

    // Reset state.
    repeat (3) @(negedge ck);
    check("rst_busy_done", 32'({bus.busy, bus.done}), 32'(0));
    check("rst_result", 32'({bus.cout, bus.sum}), 32'(0));
    check("rst_fa", 32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 32'(0));

    // Directed cases; the first also releases reset on the accepting edge.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, "add_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "ripple_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "all_ones_cin");
    run_op(8'h81, 8'h7E, 1'b1, 1'b1, 1'b0, "ignore_busy_start");
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "zero_plus_zero");

    // Reset asserted mid-SHIFT at counter=4 (cycle 5 after accept).
    @(negedge ck);
    bus.op_a  = 8'hAB;
    bus.op_b  = 8'hCD;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge ck);
    @(negedge ck);
    bus.start = 1'b0;
    repeat (4) @(negedge ck);
    check("pre_abort_busy", 32'(bus.busy), 32'(1));
    rst = 1'b0;
    #1;
    check("abort_busy_done", 32'({bus.busy, bus.done}), 32'(0));
    check("abort_result", 32'({bus.cout, bus.sum}), 32'(0));
    check("abort_fa", 32'({bus.fa_a, bus.fa_b, bus.fa_ci}), 32'(0));
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      check("abort_no_done", 32'({bus.busy, bus.done}), 32'(0));
    end
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, "after_abort");

    // Random regression with start held high continuously.
    @(negedge ck);
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom);
    bus.op_a  = ra;
    bus.op_b  = rb;
    bus.cin   = rc;
    bus.start = 1'b1;
    exp_q.push_back(model_add(ra, rb, rc));
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      waited = 0;
      do begin
        @(negedge ck);
        waited++;
      end while (!bus.done && waited < 3 * W);
      check("rand_done_seen", 32'(bus.done), 32'(1));
      if (!bus.done) break;
      e = exp_q.pop_front();
      check("rand_result", 32'({bus.cout, bus.sum}), 32'(e));
      if (last_done >= 0) begin
        check("rand_spacing", 32'(cyc - last_done), 32'(W + 3));
      end
      last_done = cyc;
      if (i < 999) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        bus.op_a = ra;
        bus.op_b = rb;
        bus.cin  = rc;
        exp_q.push_back(model_add(ra, rb, rc));
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge ck);
    check("rand_idle_end", 32'({bus.busy, bus.done}), 32'(0));
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    // Final report.
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
